gcd_master: RTL
===============

GCD_MASTER -- requirements
Module: gcd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abandoning a job; legal range 2..65535.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  operand pair offered.
REQ-005 req_ready  output  1  block accepts the operand pair this cycle.
REQ-006 req_a, req_b  input  32 each  unsigned operands.
REQ-007 rsp_valid  output  1  response payload valid.
REQ-008 rsp_ready  input  1  consumer accepts the response.
REQ-009 rsp_gcd  output  32  GCD result.
REQ-010 rsp_timeout  output  1  job abandoned; rsp_gcd is 0.
REQ-011 rsp_cycles  output  16  engine-occupancy cycle count, saturating.
REQ-012 eng_a, eng_b  output  32 each  operands to GCD engine.
REQ-013 eng_start  output  1  single-cycle engine start pulse.
REQ-014 eng_done  input  1  engine completion pulse.
REQ-015 eng_result  input  32  engine result, valid while eng_done is high.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 exactly when the state is IDLE.
REQ-018 Acceptance (req_valid&&req_ready) SHALL latch req_a/req_b into the operand registers, which drive eng_a/eng_b continuously.
REQ-019 Bypass: if either accepted operand is 0, the FSM SHALL go IDLE->RESP with rsp_gcd=req_a|req_b, rsp_timeout=0, rsp_cycles=0, and SHALL NOT pulse eng_start.
REQ-020 Otherwise the FSM SHALL go IDLE->ISSUE, and eng_start SHALL be 1 for exactly the single ISSUE cycle (the cycle after acceptance).
REQ-021 ISSUE SHALL go unconditionally to WAIT, with the WAIT counter cleared to 0.
REQ-022 In WAIT with eng_done=1, the block SHALL capture eng_result into rsp_gcd, set rsp_timeout=0, and go to RESP.
REQ-023 In WAIT with eng_done=0 and counter==TIMEOUT_CYCLES-1, the block SHALL set rsp_gcd=0, set rsp_timeout=1, and go to RESP.
REQ-024 In WAIT otherwise, the counter SHALL increment.
REQ-025 When eng_done and the timeout condition occur in the same cycle, done SHALL take priority.
REQ-026 rsp_cycles SHALL equal the number of cycles spent in ISSUE plus WAIT (including the done/timeout cycle), saturating at 16'hFFFF.
REQ-027 rsp_valid SHALL be 1 exactly in RESP, with rsp_gcd, rsp_timeout and rsp_cycles held stable until rsp_valid&&rsp_ready, which SHALL return the FSM to IDLE.
REQ-028 eng_done received outside WAIT (for example, late after a timeout) SHALL be ignored and SHALL NOT alter the response registers.
REQ-029 No new request SHALL be accepted in the cycle a response handshakes; the earliest next acceptance is the following cycle.

Reset
REQ-030 While reset_n is 0: state=IDLE; req_ready=1; rsp_valid=0; eng_start=0; rsp_gcd, rsp_timeout, rsp_cycles, eng_a, eng_b and the WAIT counter all 0.
REQ-031 Reset asserted in any state, including mid-WAIT or RESP, SHALL abandon the job with no response emitted.

Structure
REQ-032 Package gcd_pkg SHALL hold the state enum type, operand width constant (32) and cycle-count width constant (16).
REQ-033 No sub-module is required; the GCD engine is a sibling instance connected at the parent level, and the saturating counter is inline.

Verification
REQ-034 Send (48,18) to the real engine -> eng_start pulses once in the cycle after acceptance; rsp_gcd=6, rsp_timeout=0, rsp_cycles>=2.
REQ-035 Send (0,35) -> rsp_valid in the cycle after acceptance; rsp_gcd=35, rsp_cycles=0, eng_start never asserted.
REQ-036 TIMEOUT_CYCLES=8 with a stub engine that never asserts done, send (7,3) -> rsp_timeout=1, rsp_gcd=0, rsp_cycles=9; a stub done issued 3 cycles later is ignored.
REQ-037 TIMEOUT_CYCLES=8 with a stub that asserts done with result 5 on the 8th WAIT cycle -> rsp_timeout=0, rsp_gcd=5, rsp_cycles=9.
REQ-038 Hold rsp_ready=0 for 5 cycles after response (9,6) -> rsp_gcd=3 stable throughout and req_ready=0 until the handshake.
REQ-039 Pulse reset_n low mid-WAIT -> all outputs match REQ-030 and no rsp_valid is seen; a subsequent (100,75) returns 25.

Source files
------------

// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD job master: the controller state encoding,
// the operand width and the width of the engine-occupancy cycle counter.
// No ports (package).
// -----------------------------------------------------------------------------
package gcd_pkg;

    localparam int OPERAND_W = 32;
    localparam int CYCLE_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
        return (v == '1) ? v : v + CYCLE_W'(1);
    endfunction

endpackage

// File: rtl/gcd_master.sv
// -----------------------------------------------------------------------------
// gcd_master
// Accepts an operand pair, hands it to an external GCD engine, waits for the
// engine's completion (with a timeout) and returns a single response.
// Operands where either value is zero are answered directly without using the
// engine.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   req_valid    operand pair offered
//   req_ready    block is idle and accepts the pair this cycle
//   req_a/req_b  32-bit unsigned operands
//   rsp_valid    response payload valid (held until rsp_ready)
//   rsp_ready    consumer accepts the response
//   rsp_gcd      GCD result (0 on timeout)
//   rsp_timeout  job abandoned because the engine did not finish in time
//   rsp_cycles   cycles spent in ISSUE + WAIT, saturating
//   eng_a/eng_b  operands presented to the engine (held from acceptance)
//   eng_start    one-cycle start pulse to the engine
//   eng_done     engine completion pulse
//   eng_result   engine result, valid while eng_done is high
// -----------------------------------------------------------------------------
module gcd_master
    import gcd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OPERAND_W-1:0] req_a,
    input  logic [OPERAND_W-1:0] req_b,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OPERAND_W-1:0] rsp_gcd,
    output logic                 rsp_timeout,
    output logic [CYCLE_W-1:0]   rsp_cycles,

    output logic [OPERAND_W-1:0] eng_a,
    output logic [OPERAND_W-1:0] eng_b,
    output logic                 eng_start,
    input  logic                 eng_done,
    input  logic [OPERAND_W-1:0] eng_result
);

    // Last WAIT counter value before the job is abandoned.
    localparam logic [CYCLE_W-1:0] WAIT_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q,     state_d;
    logic [OPERAND_W-1:0] a_q,         a_d;
    logic [OPERAND_W-1:0] b_q,         b_d;
    logic [CYCLE_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [CYCLE_W-1:0]   cycles_q,    cycles_d;
    logic [OPERAND_W-1:0] gcd_q,       gcd_d;
    logic                 timeout_q,   timeout_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 eng_start_q, eng_start_d;

    logic accept;

    assign accept = req_valid && req_ready_q;

    // Next-state and next-output logic. All outputs are registered, so each
    // transition also sets the output values the destination state presents.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        wait_cnt_d  = wait_cnt_q;
        cycles_d    = cycles_q;
        gcd_d       = gcd_q;
        timeout_d   = timeout_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        eng_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d         = req_a;
                    b_d         = req_b;
                    req_ready_d = 1'b0;
                    // gcd(x,0) = x, so a zero operand needs no engine run.
                    if (req_a == '0 || req_b == '0) begin
                        gcd_d       = req_a | req_b;
                        timeout_d   = 1'b0;
                        cycles_d    = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        eng_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end

            ISSUE: begin
                // The ISSUE cycle itself is the first occupied cycle.
                wait_cnt_d = '0;
                cycles_d   = CYCLE_W'(1);
                state_d    = WAIT;
            end

            WAIT: begin
                cycles_d = sat_inc(cycles_q);
                // Completion wins over a simultaneous timeout.
                if (eng_done) begin
                    gcd_d       = eng_result;
                    timeout_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    gcd_d       = '0;
                    timeout_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CYCLE_W'(1);
                end
            end

            RESP: begin
                // req_ready only rises on the cycle after the handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any job in flight silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            wait_cnt_q  <= '0;
            cycles_q    <= '0;
            gcd_q       <= '0;
            timeout_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            wait_cnt_q  <= wait_cnt_d;
            cycles_q    <= cycles_d;
            gcd_q       <= gcd_d;
            timeout_q   <= timeout_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            eng_start_q <= eng_start_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_gcd     = gcd_q;
    assign rsp_timeout = timeout_q;
    assign rsp_cycles  = cycles_q;
    assign eng_a       = a_q;
    assign eng_b       = b_q;
    assign eng_start   = eng_start_q;

endmodule
